// File: rtl/lsrt_pkg.sv
// Shared encodings for the lsrt transmit scheduler and the lstx transmitter.
package lsrt_pkg;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_PUSH = 3'd2;
  localparam logic [2:0] ST_WLO  = 3'd3;
  localparam logic [2:0] ST_WHI  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    StInit = ST_INIT,
    StIdle = ST_IDLE,
    StPush = ST_PUSH,
    StWlo  = ST_WLO,
    StWhi  = ST_WHI,
    StDone = ST_DONE
  } sched_state_e;

  // lstx shifter states, kept here so both sides agree on the encoding
  localparam logic [1:0] LSTX_IDLE  = 2'd0;
  localparam logic [1:0] LSTX_START = 2'd1;
  localparam logic [1:0] LSTX_DATA  = 2'd2;
  localparam logic [1:0] LSTX_STOP  = 2'd3;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lsrt_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module lsrt_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            hit,
  output logic [NREQ-1:0] sel_oh,
  output logic [PW-1:0]   sel_idx
);

  // Decode ptr first so every req index below is an elaboration-time constant.
  always_comb begin
    hit     = 1'b0;
    sel_oh  = '0;
    sel_idx = '0;
    for (int unsigned p = 0; p < NREQ; p++) begin
      if (ptr == PW'(p)) begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          if (!hit && req[(p + k) % NREQ]) begin
            hit                     = 1'b1;
            sel_oh[(p + k) % NREQ]  = 1'b1;
            sel_idx                 = PW'((p + k) % NREQ);
          end
        end
      end
    end
  end

endmodule

// File: rtl/lsrt_tx_sched.sv
// Round-robin scheduler sharing one lstx transmitter between NREQ requesters.
// Define LSRT_SCHED_TMO_EN to enable the WLO/WHI watchdog (err pulse and forced release).
module lsrt_tx_sched
  import lsrt_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DMSB = 9,
  parameter int unsigned CMSB = 12,
  parameter int unsigned TMO  = 4095
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     setn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*(DMSB+1)-1:0] wdata_in,
  input  logic [NREQ*(CMSB+1)-1:0] div_in,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     err,
  output logic                     tx_push,
  output logic                     tx_clear,
  output logic [CMSB:0]            tx_div,
  output logic [DMSB:0]            tx_wdata,
  input  logic                     tx_empty
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned DW = DMSB + 1;
  localparam int unsigned VW = CMSB + 1;

  if (NREQ < 2 || NREQ > 8 || TMO == 0) begin : g_bad_param
    $error("lsrt_tx_sched: NREQ must be 2..8 and TMO nonzero");
  end

  sched_state_e    state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            push_q, push_d;
  logic            clear_q, clear_d;
  logic [CMSB:0]   div_q, div_d;
  logic [DMSB:0]   wdata_q, wdata_d;

`ifdef LSRT_SCHED_TMO_EN
  localparam int unsigned CW = $clog2(TMO + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  logic            pick_hit;
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic [DMSB:0]   sel_wdata;
  logic [CMSB:0]   sel_div;
  logic [PW-1:0]   ptr_nxt;

  lsrt_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .hit     (pick_hit),
    .sel_oh  (pick_oh),
    .sel_idx (pick_idx)
  );

  always_comb begin
    sel_wdata = '0;
    sel_div   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_wdata = wdata_in[i*DW +: DW];
        sel_div   = div_in[i*VW +: VW];
      end
    end
  end

  assign ptr_nxt = PW'(rr_next(32'(gidx_q), NREQ));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    push_d  = push_q;
    clear_d = clear_q;
    div_d   = div_q;
    wdata_d = wdata_q;
`ifdef LSRT_SCHED_TMO_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StInit: begin
        clear_d = ~clear_q;
        state_d = StIdle;
      end
      StIdle: begin
        if (pick_hit && tx_empty) begin
          wdata_d = sel_wdata;
          div_d   = sel_div;
          gnt_d   = pick_oh;
          gidx_d  = pick_idx;
          state_d = StPush;
        end
      end
      StPush: begin
        push_d  = ~push_q;
`ifdef LSRT_SCHED_TMO_EN
        cnt_d   = '0;
`endif
        state_d = StWlo;
      end
      StWlo: if (!tx_empty) state_d = StWhi;
      StWhi: if (tx_empty) state_d = StDone;
      StDone: begin
        ack_d   = gnt_q;
        gnt_d   = '0;
        ptr_d   = ptr_nxt;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
`ifdef LSRT_SCHED_TMO_EN
    // Watchdog overrides the normal WLO/WHI progress and flushes lstx.
    if (state_q == StWlo || state_q == StWhi) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(TMO)) begin
        err_d   = 1'b1;
        ack_d   = gnt_q;
        gnt_d   = '0;
        clear_d = ~clear_q;
        ptr_d   = ptr_nxt;
        state_d = StIdle;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      push_q  <= 1'b0;
      clear_q <= 1'b0;
      div_q   <= '0;
      wdata_q <= '0;
`ifdef LSRT_SCHED_TMO_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else if (setn) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      push_q  <= push_d;
      clear_q <= clear_d;
      div_q   <= div_d;
      wdata_q <= wdata_d;
`ifdef LSRT_SCHED_TMO_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign gnt      = gnt_q;
  assign busy     = (state_q != StIdle);
  assign tx_push  = push_q;
  assign tx_clear = clear_q;
  assign tx_div   = div_q;
  assign tx_wdata = wdata_q;
`ifdef LSRT_SCHED_TMO_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
